axi4lite_regfile_slave: RTL and testbench

AXI4LITE_REGFILE_SLAVE -- requirements
Module: axi4lite_regfile_slave

---
 rtl/axi4lite_regfile_slave.sv | 169 ++++++++++++++++
 tb/tb_axi4lite_regfile_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register file slave: NUM_REGS-1 byte-strobed RW registers plus a
// read-only top register that counts successful write commits.
module axi4lite_regfile_slave #(
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 2,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 8
) (
   input  logic                                                   m_axi_aclk,
   input  logic                                                   m_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                          s_axi_awaddr,
   input  logic                                                   s_axi_awvalid,
   output logic                                                   s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]                          s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                        s_axi_wstrb,
   input  logic                                                   s_axi_wvalid,
   output logic                                                   s_axi_wready,
   output logic [1:0]                                             s_axi_bresp,
   output logic                                                   s_axi_bvalid,
   input  logic                                                   s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                          s_axi_araddr,
   input  logic                                                   s_axi_arvalid,
   output logic                                                   s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]                          s_axi_rdata,
   output logic [1:0]                                             s_axi_rresp,
   output logic                                                   s_axi_rvalid,
   input  logic                                                   s_axi_rready,
   output logic [(2**C_S_AXI_ADDR_WIDTH)*C_S_AXI_DATA_WIDTH-1:0]  regs_out
);

   localparam int unsigned ADDR_W   = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned DATA_W   = C_S_AXI_DATA_WIDTH;
   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] TOP_IDX = ADDR_W'(NUM_REGS - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_ACCEPT, W_RESP} wstate_e;
   typedef enum logic {R_ACCEPT, R_DATA} rstate_e;

   wstate_e wstate;
   rstate_e rstate;

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;

   logic              aw_held;
   logic              w_held;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [STRB_W-1:0] strb_q;

   logic              aw_hs_c;
   logic              w_hs_c;
   logic              ar_hs_c;
   logic              commit_c;
   logic              top_hit_c;
   logic [ADDR_W-1:0] cm_addr_c;
   logic [DATA_W-1:0] cm_data_c;
   logic [STRB_W-1:0] cm_strb_c;

   assign regs_out = regs;

   // Handshakes and the write payload, taken from the latch or straight off the bus
   always_comb begin
      aw_hs_c   = s_axi_awvalid & s_axi_awready;
      w_hs_c    = s_axi_wvalid & s_axi_wready;
      ar_hs_c   = s_axi_arvalid & s_axi_arready;
      cm_addr_c = aw_held ? addr_q : s_axi_awaddr;
      cm_data_c = w_held ? data_q : s_axi_wdata;
      cm_strb_c = w_held ? strb_q : s_axi_wstrb;
      commit_c  = (wstate == W_ACCEPT) & (aw_held | aw_hs_c) & (w_held | w_hs_c);
      top_hit_c = (cm_addr_c == TOP_IDX);
   end

   // Write FSM, address/data latches and register updates
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         wstate        <= W_ACCEPT;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         strb_q        <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         regs          <= '0;
      end else begin
         case (wstate)
            W_ACCEPT: begin
               if (commit_c) begin
                  wstate        <= W_RESP;
                  aw_held       <= 1'b0;
                  w_held        <= 1'b0;
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b0;
                  s_axi_bvalid  <= 1'b1;
                  if (top_hit_c) begin
                     s_axi_bresp <= RESP_SLVERR;
                  end else begin
                     s_axi_bresp <= RESP_OKAY;
                     for (int b = 0; b < int'(STRB_W); b++) begin
                        if (cm_strb_c[b]) begin
                           regs[cm_addr_c][8*b +: 8] <= cm_data_c[8*b +: 8];
                        end
                     end
                     regs[TOP_IDX] <= regs[TOP_IDX] + DATA_W'(1);
                  end
               end else begin
                  if (aw_hs_c) begin
                     aw_held <= 1'b1;
                     addr_q  <= s_axi_awaddr;
                  end
                  if (w_hs_c) begin
                     w_held <= 1'b1;
                     data_q <= s_axi_wdata;
                     strb_q <= s_axi_wstrb;
                  end
                  s_axi_awready <= ~(aw_held | aw_hs_c);
                  s_axi_wready  <= ~(w_held | w_hs_c);
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  wstate        <= W_ACCEPT;
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  s_axi_wready  <= 1'b1;
               end
            end
            default: wstate <= W_ACCEPT;
         endcase
      end
   end

   // Read FSM; sampling regs before this edge's write gives read-before-write ordering
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         rstate        <= R_ACCEPT;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rdata   <= '0;
      end else begin
         case (rstate)
            R_ACCEPT: begin
               if (ar_hs_c) begin
                  rstate        <= R_DATA;
                  s_axi_rdata   <= regs[s_axi_araddr];
                  s_axi_rresp   <= RESP_OKAY;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_arready <= 1'b0;
               end else begin
                  s_axi_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  rstate        <= R_ACCEPT;
                  s_axi_rvalid  <= 1'b0;
                  s_axi_arready <= 1'b1;
               end
            end
            default: rstate <= R_ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Randomized self-checking bench for axi4lite_regfile_slave against a
// transaction-level register model.
module tb_axi4lite_regfile_slave;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int SW = DW / 8;
   localparam int NR = 2 ** AW;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [AW-1:0]    awaddr = '0;
   logic             awvalid = 1'b0;
   logic             awready;
   logic [DW-1:0]    wdata = '0;
   logic [SW-1:0]    wstrb = '0;
   logic             wvalid = 1'b0;
   logic             wready;
   logic [1:0]       bresp;
   logic             bvalid;
   logic             bready = 1'b0;
   logic [AW-1:0]    araddr = '0;
   logic             arvalid = 1'b0;
   logic             arready;
   logic [DW-1:0]    rdata;
   logic [1:0]       rresp;
   logic             rvalid;
   logic             rready = 1'b0;
   logic [NR*DW-1:0] regs_out;

   always #5 clk = ~clk;

   axi4lite_regfile_slave #(
      .C_S_AXI_ADDR_WIDTH(AW),
      .C_S_AXI_DATA_WIDTH(DW)
   ) dut (
      .m_axi_aclk   (clk),
      .m_axi_aresetn(rst_n),
      .s_axi_awaddr (awaddr),
      .s_axi_awvalid(awvalid),
      .s_axi_awready(awready),
      .s_axi_wdata  (wdata),
      .s_axi_wstrb  (wstrb),
      .s_axi_wvalid (wvalid),
      .s_axi_wready (wready),
      .s_axi_bresp  (bresp),
      .s_axi_bvalid (bvalid),
      .s_axi_bready (bready),
      .s_axi_araddr (araddr),
      .s_axi_arvalid(arvalid),
      .s_axi_arready(arready),
      .s_axi_rdata  (rdata),
      .s_axi_rresp  (rresp),
      .s_axi_rvalid (rvalid),
      .s_axi_rready (rready),
      .regs_out     (regs_out)
   );

   logic [DW-1:0] mregs [NR];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] f;
      for (int i = 0; i < NR; i++) f[i*DW +: DW] = mregs[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) mregs[i] = '0;
   endtask

   // Register-file semantics: top register is a read-only count of OKAY writes
   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s, output logic [1:0] resp);
      if (int'(a) == NR - 1) begin
         resp = 2'b10;
      end else begin
         resp = 2'b00;
         for (int b = 0; b < SW; b++)
            if (s[b]) mregs[a][8*b +: 8] = d[8*b +: 8];
         mregs[NR-1] = mregs[NR-1] + 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      rst_n = 1'b0;
      tick();
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      rst_n = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
      logic [1:0] exp_resp;
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int cyc = 0;
      model_write(a, d, s, exp_resp);
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && cyc < 50) begin
         awvalid = !aw_done && cyc >= aw_dly;
         wvalid  = !w_done && cyc >= w_dly;
         if (w_done && !aw_done) check("wready_while_w_held", wready, 0);
         if (aw_done && !w_done) check("awready_while_aw_held", awready, 0);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         aw_done = aw_done | aw_hs;
         w_done  = w_done | w_hs;
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("write_handshakes_done", aw_done && w_done, 1);
      check("bvalid_after_commit", bvalid, 1);
      check("bresp", bresp, exp_resp);
      check("regs_out_after_commit", regs_out, model_flat());
      for (int i = 0; i < b_dly; i++) begin
         bready = 1'b0;
         tick();
         check("bvalid_hold", bvalid, 1);
         check("bresp_hold", bresp, exp_resp);
         check("awready_in_resp", awready, 0);
         check("wready_in_resp", wready, 0);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("bvalid_fall", bvalid, 0);
      check("awready_back", awready, 1);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int r_dly);
      logic [DW-1:0] exp = mregs[a];
      bit hs = 0;
      int cyc = 0;
      araddr = a; arvalid = 1'b1;
      while (!hs && cyc < 20) begin
         hs = arready;
         tick();
         cyc++;
      end
      arvalid = 1'b0;
      check("ar_handshake", hs, 1);
      check("rvalid", rvalid, 1);
      check("rdata", rdata, exp);
      check("rresp", rresp, 0);
      for (int i = 0; i < r_dly; i++) begin
         tick();
         check("rvalid_hold", rvalid, 1);
         check("rdata_hold", rdata, exp);
         check("arready_in_rdata", arready, 0);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check("rvalid_fall", rvalid, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] r;
      logic [DW-1:0] old;
      model_reset();
      tick();
      check("rst_regs_out", regs_out, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_awready", awready, 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_awready", awready, 1);
      check("post_rst_wready", wready, 1);
      check("post_rst_arready", arready, 1);

      // Directed scenarios
      do_write(2'd1, 8'hA5, 1'b1, 0, 0, 0);
      check("reg1_a5", regs_out[15:8], 8'hA5);
      check("counter_one", regs_out[31:24], 8'h01);
      do_write(2'd2, 8'h3C, 1'b1, 3, 0, 0);
      check("reg2_3c", regs_out[23:16], 8'h3C);
      do_write(2'd3, 8'hFF, 1'b1, 0, 0, 0);
      check("top_unchanged", regs_out[31:24], 8'h02);
      do_write(2'd0, 8'h5A, 1'b1, 0, 1, 5);
      do_write(2'd1, 8'hFF, 1'b0, 2, 0, 1);
      check("strb0_unchanged", regs_out[15:8], 8'hA5);

      // Same-edge read and write to one address returns the old value
      do_write(2'd0, 8'h11, 1'b1, 0, 0, 0);
      old = mregs[0];
      awaddr = 2'd0; wdata = 8'h22; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 2'd0; arvalid = 1'b1;
      model_write(2'd0, 8'h22, 1'b1, r);
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("rw_same_edge_rdata", rdata, 8'h11);
      check("rw_same_edge_model", old, 8'h11);
      check("rw_same_edge_bvalid", bvalid, 1);
      check("rw_same_edge_rvalid", rvalid, 1);
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      do_read(2'd0, 0);
      check("read_new_22", regs_out[7:0], 8'h22);

      // Random traffic
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 1) == 0)
            do_write(AW'($urandom_range(0, NR-1)), DW'($urandom), SW'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
         else
            do_read(AW'($urandom_range(0, NR-1)), int'($urandom_range(0, 2)));
      end

      // Counter wrap after 256 OKAY writes from reset
      apply_reset();
      for (int n = 0; n < 256; n++)
         do_write(AW'($urandom_range(0, NR-2)), DW'($urandom), SW'($urandom), 0, 0, 0);
      check("counter_wrap", regs_out[31:24], 8'h00);
      do_read(2'd3, 0);

      // Reset with a response pending
      awaddr = 2'd1; wdata = 8'h77; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check("pre_reset_bvalid", bvalid, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_regs", regs_out, 0);
      check("async_rst_bvalid", bvalid, 0);
      tick();
      rst_n = 1'b1;
      model_reset();
      tick();
      check("after_rst_bvalid", bvalid, 0);

      // Reset with only the address latched: the stale address must not commit
      awaddr = 2'd2; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("aw_latched", awready, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      wdata = 8'h99; wstrb = 1'b1; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("no_stale_commit_bvalid", bvalid, 0);
         check("no_stale_commit_regs", regs_out, 0);
         tick();
      end
      awaddr = 2'd1; awvalid = 1'b1;
      model_write(2'd1, 8'h99, 1'b1, r);
      tick();
      awvalid = 1'b0;
      check("late_aw_bvalid", bvalid, 1);
      check("late_aw_bresp", bresp, r);
      check("late_aw_regs", regs_out, model_flat());
      bready = 1'b1;
      tick();
      bready = 1'b0;
      do_read(2'd1, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
